// File: rtl/irq_ctrl_pkg.sv
// rtl/irq_ctrl_pkg.sv - shared widths, types and winner search for irq_ctrl
package irq_ctrl_pkg;
  localparam int NUM_IRQ  = 16;
  localparam int IRQ_ID_W = 4;

  typedef logic [NUM_IRQ-1:0] irq_vec_t;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_t;

  // First set bit at or after start, wrapping 15->0.
  function automatic logic [IRQ_ID_W-1:0] pick_from(irq_vec_t vec, logic [IRQ_ID_W-1:0] start);
    logic [IRQ_ID_W-1:0] idx;
    logic                found;
    pick_from = '0;
    found     = 1'b0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      idx = start + IRQ_ID_W'(k);
      if (!found && vec[idx]) begin
        pick_from = idx;
        found     = 1'b1;
      end
    end
  endfunction
endpackage

// File: rtl/irq_sync.sv
// rtl/irq_sync.sv - two-flop synchroniser plus rising-edge detector per line
module irq_sync
  import irq_ctrl_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_IRQ-1:0] i_irq,
  output logic [NUM_IRQ-1:0] o_rise
);
  logic [NUM_IRQ-1:0] r_meta;
  logic [NUM_IRQ-1:0] r_sync;
  logic [NUM_IRQ-1:0] r_prev;
  logic [1:0]         r_warm;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= '0;
      r_sync <= '0;
      r_prev <= '0;
      r_warm <= 2'd0;
    end else begin
      r_meta <= i_irq;
      r_sync <= r_meta;
      r_prev <= r_sync;
      if (r_warm != 2'd3) r_warm <= r_warm + 2'd1;
    end
  end

  // Edges stay masked until the whole pipe holds post-reset samples, so lines
  // already high when reset releases are not mistaken for new edges.
  assign o_rise = (r_warm == 2'd3) ? (r_sync & ~r_prev) : '0;
endmodule

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - interrupt controller: pending/mask/in-service, offer FSM, EOI pulse unit
// Define IRQ_CTRL_RR_EN for round-robin arbitration; default is fixed lowest-index priority.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int EOI_PULSE_LEN = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_IRQ-1:0]  irq_in,
  input  logic                mask_we,
  input  logic [NUM_IRQ-1:0]  mask_wdata,
  output logic                irq_valid,
  output logic [IRQ_ID_W-1:0] irq_id,
  input  logic                irq_ack,
  input  logic                eoi_req,
  input  logic [IRQ_ID_W-1:0] eoi_id,
  output logic                eoi_ready,
  output logic [NUM_IRQ-1:0]  eoi_out,
  output logic [NUM_IRQ-1:0]  pending,
  output logic [NUM_IRQ-1:0]  in_service
);
  localparam logic [3:0] PULSE_LEN = 4'(EOI_PULSE_LEN);

  arb_state_t          r_state;
  logic                r_irq_valid;
  logic [IRQ_ID_W-1:0] r_irq_id;
  irq_vec_t            r_mask;
  irq_vec_t            r_pending;
  irq_vec_t            r_in_service;
  irq_vec_t            r_eoi_out;
  logic                r_eoi_ready;
  logic [3:0]          r_eoi_cnt;

  irq_vec_t            w_rise;
  irq_vec_t            w_eligible;
  irq_vec_t            w_ack_vec;
  irq_vec_t            w_eoi_vec;
  logic                w_ack_fire;
  logic                w_eoi_fire;
  logic [IRQ_ID_W-1:0] w_start;
  logic [IRQ_ID_W-1:0] w_winner;

  irq_sync u_sync (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_irq  (irq_in),
    .o_rise (w_rise)
  );

  assign w_eligible = r_pending & r_mask & ~r_in_service;
  assign w_ack_fire = (r_state == OFFER) && irq_ack;
  assign w_ack_vec  = w_ack_fire ? (irq_vec_t'(1) << r_irq_id) : '0;
  assign w_eoi_fire = eoi_req && r_eoi_ready && r_in_service[eoi_id];
  assign w_eoi_vec  = w_eoi_fire ? (irq_vec_t'(1) << eoi_id) : '0;

`ifdef IRQ_CTRL_RR_EN
  logic [IRQ_ID_W-1:0] r_rr_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             r_rr_ptr <= '1;
    else if (w_ack_fire) r_rr_ptr <= r_irq_id;
  end

  assign w_start = r_rr_ptr + IRQ_ID_W'(1);
`else
  assign w_start = '0;
`endif

  assign w_winner = pick_from(w_eligible, w_start);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_irq_valid <= 1'b0;
      r_irq_id    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_eligible != '0) begin
            r_state     <= OFFER;
            r_irq_valid <= 1'b1;
            r_irq_id    <= w_winner;
          end
        end
        OFFER: begin
          if (irq_ack) begin
            r_state     <= IDLE;
            r_irq_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // A fresh edge wins over the ack-clear so a re-raised line is not lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mask       <= '0;
      r_pending    <= '0;
      r_in_service <= '0;
    end else begin
      if (mask_we) r_mask <= mask_wdata;
      r_pending    <= (r_pending & ~w_ack_vec) | w_rise;
      r_in_service <= (r_in_service & ~w_eoi_vec) | w_ack_vec;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_eoi_out   <= '0;
      r_eoi_ready <= 1'b1;
      r_eoi_cnt   <= 4'd0;
    end else if (w_eoi_fire) begin
      r_eoi_out   <= w_eoi_vec;
      r_eoi_ready <= 1'b0;
      r_eoi_cnt   <= PULSE_LEN;
    end else if (r_eoi_cnt != 4'd0) begin
      r_eoi_cnt <= r_eoi_cnt - 4'd1;
      if (r_eoi_cnt == 4'd1) begin
        r_eoi_out   <= '0;
        r_eoi_ready <= 1'b1;
      end
    end
  end

  assign irq_valid  = r_irq_valid;
  assign irq_id     = r_irq_id;
  assign eoi_ready  = r_eoi_ready;
  assign eoi_out    = r_eoi_out;
  assign pending    = r_pending;
  assign in_service = r_in_service;
endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - scoreboard bench for irq_ctrl (offers and EOI pulses)
module tb_irq_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] irq_in;
  logic        mask_we;
  logic [15:0] mask_wdata;
  logic        irq_valid;
  logic [3:0]  irq_id;
  logic        irq_ack;
  logic        eoi_req;
  logic [3:0]  eoi_id;
  logic        eoi_ready;
  logic [15:0] eoi_out;
  logic [15:0] pending;
  logic [15:0] in_service;

  int          checks = 0;
  int          errors = 0;
  logic [3:0]  exp_q[$];
  logic [15:0] eoi_q[$];
  logic [3:0]  held_id;

  irq_ctrl #(.EOI_PULSE_LEN(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .irq_in     (irq_in),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .irq_valid  (irq_valid),
    .irq_id     (irq_id),
    .irq_ack    (irq_ack),
    .eoi_req    (eoi_req),
    .eoi_id     (eoi_id),
    .eoi_ready  (eoi_ready),
    .eoi_out    (eoi_out),
    .pending    (pending),
    .in_service (in_service)
  );

  always #5 clk = ~clk;

  task automatic wait_valid(input int budget, output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    while (!ok && cyc < budget) begin
      if (irq_valid === 1'b1) ok = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
  endtask

  task automatic do_ack();
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
  endtask

  task automatic write_mask(input logic [15:0] v);
    mask_we    = 1'b1;
    mask_wdata = v;
    @(negedge clk);
    mask_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; irq_in = '0; mask_we = 1'b0; mask_wdata = '0;
    irq_ack = 1'b0; eoi_req = 1'b0; eoi_id = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({irq_valid, irq_id, eoi_ready, eoi_out, pending, in_service} !== {1'b0, 4'h0, 1'b1, 48'h0}) begin
      errors++;
      $display("FAIL reset_outputs: got v=%0b id=%0d rdy=%0b eoi=%h pend=%h ins=%h want v=0 id=0 rdy=1 rest 0",
               irq_valid, irq_id, eoi_ready, eoi_out, pending, in_service);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_priority();
    int cyc; bit ok; logic [3:0] e;
    write_mask(16'hFFFF);
    exp_q.push_back(4'd5);
    irq_in[5] = 1'b1;
    wait_valid(12, cyc, ok);
    checks++;
    if (!ok || cyc > 4) begin
      errors++; $display("FAIL latency_line5: got ok=%0b cycles=%0d want ok=1 cycles<=4", ok, cyc);
    end
    checks++;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'hx;
    if (irq_id !== e) begin errors++; $display("FAIL offer_line5: got %0d want %0d", irq_id, e); end
    do_ack();
    irq_in[5] = 1'b0;
    checks++;
    if ({pending[5], in_service[5]} !== 2'b01) begin
      errors++; $display("FAIL ack_line5: got pend=%0b ins=%0b want pend=0 ins=1", pending[5], in_service[5]);
    end
    repeat (3) @(negedge clk);
`ifdef IRQ_CTRL_RR_EN
    exp_q.push_back(4'd9); exp_q.push_back(4'd3);
`else
    exp_q.push_back(4'd3); exp_q.push_back(4'd9);
`endif
    irq_in[3] = 1'b1; irq_in[9] = 1'b1;
    for (int n = 0; n < 2; n++) begin
      wait_valid(12, cyc, ok);
      checks++;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'hx;
      if (!ok || irq_id !== e) begin
        errors++; $display("FAIL offer_pair%0d: got ok=%0b id=%0d want id %0d", n, ok, irq_id, e);
      end
      if (n == 0) do_ack();
      else held_id = e;
    end
    irq_in[3] = 1'b0; irq_in[9] = 1'b0;
  endtask

  task automatic test_offer_hold();
    int cyc; bit ok; logic [3:0] e;
    for (int i = 0; i < 20; i++) begin
      if (i == 3) irq_in[0] = 1'b1;
      checks++;
      if (irq_valid !== 1'b1 || irq_id !== held_id) begin
        errors++; $display("FAIL hold_offer c%0d: got v=%0b id=%0d want v=1 id=%0d", i, irq_valid, irq_id, held_id);
      end
      @(negedge clk);
    end
    checks++;
    if (pending[0] !== 1'b1) begin errors++; $display("FAIL hold_pend0: got %0b want 1", pending[0]); end
    exp_q.push_back(4'd0);
    do_ack();
    irq_in[0] = 1'b0;
    wait_valid(12, cyc, ok);
    checks++;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'hx;
    if (!ok || irq_id !== e) begin errors++; $display("FAIL offer_line0: got ok=%0b id=%0d want %0d", ok, irq_id, e); end
    do_ack();
  endtask

  task automatic test_ack_idle();
    do_ack();
    @(negedge clk);
    checks++;
    if ({irq_valid, pending, in_service} !== {1'b0, 16'h0000, 16'h0229}) begin
      errors++; $display("FAIL ack_idle: got v=%0b pend=%h ins=%h want v=0 pend=0000 ins=0229", irq_valid, pending, in_service);
    end
  endtask

  task automatic test_eoi();
    int cyc; bit ok; logic [3:0] e; logic [15:0] p;
    exp_q.push_back(4'd2);
    irq_in[2] = 1'b1;
    wait_valid(12, cyc, ok);
    checks++;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'hx;
    if (!ok || irq_id !== e) begin errors++; $display("FAIL offer_line2: got ok=%0b id=%0d want %0d", ok, irq_id, e); end
    do_ack();
    irq_in[2] = 1'b0;
    eoi_id = 4'd2; eoi_req = 1'b1; eoi_q.push_back(16'h0004);
    @(negedge clk);
    eoi_req = 1'b0;
    p = (eoi_q.size() != 0) ? eoi_q.pop_front() : 16'hxxxx;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (eoi_out !== p || eoi_ready !== 1'b0) begin
        errors++; $display("FAIL eoi_pulse c%0d: got out=%h rdy=%0b want out=%h rdy=0", i, eoi_out, eoi_ready, p);
      end
      @(negedge clk);
    end
    checks++;
    if ({eoi_out, eoi_ready, in_service[2]} !== {16'h0000, 1'b1, 1'b0}) begin
      errors++; $display("FAIL eoi_end: got out=%h rdy=%0b ins2=%0b want out=0000 rdy=1 ins2=0", eoi_out, eoi_ready, in_service[2]);
    end
  endtask

  task automatic test_eoi_ignored();
    eoi_id = 4'd7; eoi_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (eoi_ready !== 1'b1 || eoi_out !== 16'h0000) begin
        errors++; $display("FAIL eoi_ignore c%0d: got rdy=%0b out=%h want rdy=1 out=0000", i, eoi_ready, eoi_out);
      end
    end
    eoi_req = 1'b0;
  endtask

  task automatic test_mask();
    int cyc; bit ok; logic [3:0] e;
    write_mask(16'h0000);
    irq_in[4] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (irq_valid !== 1'b0) begin errors++; $display("FAIL masked_offer c%0d: got %0b want 0", i, irq_valid); end
    end
    checks++;
    if (pending[4] !== 1'b1) begin errors++; $display("FAIL masked_pend4: got %0b want 1", pending[4]); end
    irq_in[4] = 1'b0;
    exp_q.push_back(4'd4);
    write_mask(16'h0010);
    wait_valid(10, cyc, ok);
    checks++;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'hx;
    if (!ok || cyc + 1 > 2 || irq_id !== e) begin
      errors++; $display("FAIL unmask_offer: got ok=%0b cycles=%0d id=%0d want cycles<=2 id=%0d", ok, cyc + 1, irq_id, e);
    end
    do_ack();
  endtask

  task automatic test_reset_abort();
    int cyc; bit ok; logic [3:0] e; logic [15:0] p;
    write_mask(16'hFFFF);
    exp_q.push_back(4'd6);
    irq_in[6] = 1'b1;
    wait_valid(12, cyc, ok);
    checks++;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'hx;
    if (!ok || irq_id !== e) begin errors++; $display("FAIL offer_line6: got ok=%0b id=%0d want %0d", ok, irq_id, e); end
    rst = 1'b1;
    #1;
    checks++;
    if ({irq_valid, irq_id, eoi_ready, pending, in_service} !== {1'b0, 4'h0, 1'b1, 32'h0}) begin
      errors++; $display("FAIL rst_offer: got v=%0b id=%0d rdy=%0b pend=%h ins=%h want all reset", irq_valid, irq_id, eoi_ready, pending, in_service);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (irq_valid !== 1'b0 || pending !== 16'h0000) begin
        errors++; $display("FAIL post_rst_edge c%0d: got v=%0b pend=%h want v=0 pend=0000", i, irq_valid, pending);
      end
    end
    write_mask(16'hFFFF);
    exp_q.push_back(4'd1);
    irq_in[1] = 1'b1;
    wait_valid(12, cyc, ok);
    checks++;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 4'hx;
    if (!ok || irq_id !== e) begin errors++; $display("FAIL offer_line1: got ok=%0b id=%0d want %0d", ok, irq_id, e); end
    do_ack();
    eoi_id = 4'd1; eoi_req = 1'b1; eoi_q.push_back(16'h0002);
    @(negedge clk);
    eoi_req = 1'b0;
    p = (eoi_q.size() != 0) ? eoi_q.pop_front() : 16'hxxxx;
    checks++;
    if (eoi_out !== p) begin errors++; $display("FAIL eoi_line1: got %h want %h", eoi_out, p); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (eoi_out !== 16'h0000 || eoi_ready !== 1'b1) begin
      errors++; $display("FAIL rst_pulse: got out=%h rdy=%0b want out=0000 rdy=1", eoi_out, eoi_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (eoi_out !== 16'h0000 || irq_valid !== 1'b0) begin
        errors++; $display("FAIL post_rst_pulse c%0d: got out=%h v=%0b want out=0000 v=0", i, eoi_out, irq_valid);
      end
    end
    checks++;
    if (exp_q.size() != 0 || eoi_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d/%0d left want 0/0", exp_q.size(), eoi_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_offer_hold();
    test_ack_idle();
    test_eoi();
    test_eoi_ignored();
    test_mask();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have parameter EOI_PULSE_LEN, default 4: cycles each eoi_out pulse is held high; legal range 1..15.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port irq_in  input  16  raw interrupt lines from input pads, asynchronous to clk.
REQ-005 SHALL have port mask_we  input  1  mask register write strobe.
REQ-006 SHALL have port mask_wdata  input  16  new mask value; 1 = line enabled.
REQ-007 SHALL have port irq_valid  output  1  an interrupt is offered to the core.
REQ-008 SHALL have port irq_id  output  4  index of the offered interrupt.
REQ-009 SHALL have port irq_ack  input  1  core accepts the current offer.
REQ-010 SHALL have port eoi_req  input  1  core requests end-of-interrupt.
REQ-011 SHALL have port eoi_id  input  4  index being completed.
REQ-012 SHALL have port eoi_ready  output  1  EOI unit idle; eoi_req is accepted only while high.
REQ-013 SHALL have port eoi_out  output  16  to output pads; one-hot pulse per completed EOI.
REQ-014 SHALL have ports pending and in_service  output  16 each  status vectors.

Function
REQ-015 SHALL synchronise each irq_in bit through two flops, then detect rising edges with a third flop.
REQ-016 SHALL set pending[i] on a detected edge of line i, regardless of mask.
REQ-017 SHALL compute eligible = pending & mask & ~in_service.
REQ-018 Arbiter FSM SHALL have states IDLE and OFFER; IDLE->OFFER when eligible is nonzero, latching the winner into irq_id.
REQ-019 In OFFER, irq_valid SHALL be 1 and irq_id SHALL stay stable until irq_ack; mask or pending changes SHALL NOT alter the offer.
REQ-020 On OFFER with irq_ack: clear pending[id], set in_service[id], return to IDLE; the next offer appears no earlier than 1 cycle later.
REQ-021 irq_ack in IDLE SHALL be ignored.
REQ-022 When a new edge on line i coincides with the ack of i, pending[i] SHALL remain set.
REQ-023 Latency: an irq_in edge SHALL produce irq_valid no later than 4 cycles afterwards when the arbiter is idle and the line is eligible.
REQ-024 On eoi_req with eoi_ready: if in_service[eoi_id]=1, clear it, drive eoi_out[eoi_id] high for exactly EOI_PULSE_LEN cycles, and hold eoi_ready low until the pulse ends; otherwise ignore the request and keep eoi_ready high.
REQ-025 Counter-based EOI unit: eoi_ready SHALL be low from the cycle after acceptance through the last pulse cycle.
REQ-026 mask_we SHALL update the mask on the next edge; a write coinciding with an arbiter decision SHALL take effect for the following decision only.

Reset
REQ-027 On rst: mask=16'h0000, pending=0, in_service=0, synchroniser flops=0, FSM=IDLE, irq_valid=0, irq_id=0, eoi_out=0, eoi_ready=1, EOI counter=0.
REQ-028 Reset mid-offer or mid-pulse SHALL abort immediately; no eoi_out glitch after rst deasserts.
REQ-029 Lines already high at reset release SHALL NOT register an edge.

Configuration
REQ-030 Macro IRQ_CTRL_RR_EN defined: round-robin arbitration; search starts at the index after the last acknowledged id (wrap 15->0); pointer resets to 15.
REQ-031 Macro undefined: fixed priority; lowest index wins.

Structure
REQ-032 Package irq_ctrl_pkg SHALL hold NUM_IRQ=16, IRQ_ID_W=4, the arbiter state enum (IDLE, OFFER), and typedef irq_vec_t.
REQ-033 Sub-module irq_sync (2-flop synchroniser plus edge detector, per-bit vector) SHALL be instantiated once.

Verification
REQ-034 mask=FFFF, edges on 3 and 9 same cycle -> fixed priority: id 3 offered, then 9 after ack; RR after last ack=5: id 9 first.
REQ-035 Hold irq_ack low 20 cycles while an edge arrives on 0 -> irq_id stays 9, irq_valid stays 1.
REQ-036 Ack id 2, eoi_req id 2 -> eoi_out=16'h0004 for 4 cycles, eoi_ready low 4 cycles, in_service[2]=0.
REQ-037 eoi_req id 7 with in_service[7]=0 -> no pulse, eoi_ready stays 1.
REQ-038 mask=0, edge on 4 -> pending[4]=1, no offer; then mask=0010h -> offer id 4 within 2 cycles.
REQ-039 Assert rst during OFFER and during an EOI pulse -> all outputs at reset values the same cycle; no offer after release while irq_in held high.
